// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the 4-way round-robin request arbiter.
package rr_arbiter_4_pkg;
  localparam int N_REQ      = 4;
  localparam int IDX_W      = 2;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // One-hot vector with only bit i set.
  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter_4_pick.sv
// Winner search: first set request bit starting at ptr, wrapping mod 4.
module rr_pick_4
  import rr_arbiter_4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest set bit wins last.
  always_comb begin
    idx  = ptr;
    cand = '0;
    any  = |req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// 4-requester arbiter in front of a single downstream request/response port.
// One transaction in flight: IDLE picks a winner, ISSUE hands its fields
// downstream, WAIT forwards the response and advances the round-robin pointer.
// Build option: define ARB_FIXED_PRIORITY_EN for lowest-index-wins priority
// (pointer held at 0).
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [ADDR_W-1:0]    req_addr_0,
  input  logic [ADDR_W-1:0]    req_addr_1,
  input  logic [ADDR_W-1:0]    req_addr_2,
  input  logic [ADDR_W-1:0]    req_addr_3,
  input  logic [DATA_W-1:0]    req_wdata_0,
  input  logic [DATA_W-1:0]    req_wdata_1,
  input  logic [DATA_W-1:0]    req_wdata_2,
  input  logic [DATA_W-1:0]    req_wdata_3,
  input  logic [N_REQ-1:0]     req_we,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     resp_valid,
  output logic [DATA_W-1:0]    resp_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_addr,
  output logic [DATA_W-1:0]    out_wdata,
  output logic                 out_we,
  input  logic                 in_resp_valid,
  input  logic [DATA_W-1:0]    in_resp_data,
  output logic [IDX_W-1:0]     grant_sel
);

  state_t                         state, state_nxt;
  logic [IDX_W-1:0]               ptr, ptr_nxt, grant_nxt;
  logic [IDX_W-1:0]               pick_ptr, pick_idx;
  logic                           pick_any;
  logic [N_REQ-1:0][ADDR_W-1:0]   addr_v;
  logic [N_REQ-1:0][DATA_W-1:0]   wdata_v;

  assign addr_v  = {req_addr_3, req_addr_2, req_addr_1, req_addr_0};
  assign wdata_v = {req_wdata_3, req_wdata_2, req_wdata_1, req_wdata_0};

`ifdef ARB_FIXED_PRIORITY_EN
  assign pick_ptr = '0;
`else
  assign pick_ptr = ptr;
`endif

  rr_pick_4 u_pick (
    .req (req_valid),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // State, pointer and grant registers; reset drops any in-flight transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_sel <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant_sel <= grant_nxt;
    end
  end

  // Next state and all outputs; fields/responses are zero unless driven.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    grant_nxt  = grant_sel;
    out_valid  = 1'b0;
    out_addr   = '0;
    out_wdata  = '0;
    out_we     = 1'b0;
    req_ready  = '0;
    resp_valid = '0;
    resp_data  = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_nxt = pick_idx;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // Fields come from the granted requester, not re-arbitrated, so a
        // dropped req_valid mid-ISSUE cannot abort the transfer.
        out_valid = 1'b1;
        out_addr  = addr_v[grant_sel];
        out_wdata = wdata_v[grant_sel];
        out_we    = req_we[grant_sel];
        if (out_ready) begin
          req_ready = onehot(grant_sel);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // Reads and writes alike retire only on a downstream response.
        if (in_resp_valid) begin
          resp_valid = onehot(grant_sel);
          resp_data  = in_resp_data;
`ifdef ARB_FIXED_PRIORITY_EN
          ptr_nxt    = '0;
`else
          ptr_nxt    = grant_sel + 2'd1;
`endif
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
